// File: rtl/projection_router_pkg.sv
// Shared definitions for the projection router slice.
// Holds the projection word layout, the phi-region selection bits and
// the router state encoding.
package projection_router_pkg;

   // Projection word layout, MSB first: {phi, z, phider, zder, index}
   localparam int PHI_BITS  = 14;
   localparam int Z_BITS    = 12;
   localparam int PHID_BITS = 9;
   localparam int ZD_BITS   = 9;
   localparam int IDX_BITS  = 10;
   localparam int PROJ_BITS = PHI_BITS + Z_BITS + PHID_BITS + ZD_BITS + IDX_BITS;

   // Field offsets (LSB position of each field)
   localparam int IDX_LSB  = 0;
   localparam int ZD_LSB   = IDX_LSB + IDX_BITS;
   localparam int PHID_LSB = ZD_LSB + ZD_BITS;
   localparam int Z_LSB    = PHID_LSB + PHID_BITS;
   localparam int PHI_LSB  = Z_LSB + Z_BITS;

   // Four phi regions selected by the top two phi bits
   localparam int NUM_REGIONS = 4;
   localparam int REGION_MSB  = PROJ_BITS - 1;
   localparam int REGION_LSB  = PROJ_BITS - 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ROUTE = 1'b1
   } state_t;

endpackage

// File: rtl/projection_router_region.sv
// region_counter: per-region write counter for one event page.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   i_clear      new event; counter restarts (a same-cycle i_inc counts as entry 0)
//   i_inc        a projection targets this region this cycle
//   o_index      low ADDR_BITS of the count, i.e. next free slot in the page
//   o_full       region holds 2^ADDR_BITS entries for this event
//   o_overflow   sticky: a projection was dropped because the region was full
module region_counter
   import projection_router_pkg::*;
#(
   parameter int ADDR_BITS = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_clear,
   input  logic                 i_inc,
   output logic [ADDR_BITS-1:0] o_index,
   output logic                 o_full,
   output logic                 o_overflow
);

   localparam logic [ADDR_BITS:0] FULL_VAL = {1'b1, {ADDR_BITS{1'b0}}};
   localparam logic [ADDR_BITS:0] ONE_VAL  = {{ADDR_BITS{1'b0}}, 1'b1};

   logic [ADDR_BITS:0] r_count;
   logic               r_overflow;
   logic               w_full;

   assign w_full = (r_count == FULL_VAL);

   // Saturating count; a clear restarts the event, so a coincident increment
   // becomes the first entry of the new page rather than the last of the old.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (i_clear) begin
         r_count    <= i_inc ? ONE_VAL : '0;
         r_overflow <= 1'b0;
      end else if (i_inc) begin
         if (w_full) begin
            r_overflow <= 1'b1;
         end else begin
            r_count <= r_count + ONE_VAL;
         end
      end
   end

   assign o_index    = r_count[ADDR_BITS-1:0];
   assign o_full     = w_full;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/projection_router.sv
// projection_router: steers each projection into one of four phi-region
// memories, generating a per-region write address whose MSB is the event
// page, so the downstream stage reads event N-1 while event N is written.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   start        one-cycle new-event (BX) pulse
//   proj_in      54-bit projection, region = proj_in[53:52]
//   proj_valid   proj_in valid this cycle
//   proj_out     registered copy of the last accepted projection
//   wr_en_out    one-hot per-region write pulse
//   wr_addr      per-region {page, slot}, region r at [r*(ADDR_BITS+1) +: ADDR_BITS+1]
//   bx           event counter
//   overflow     sticky per-region drop flags for the current event
//   nproj        projections accepted in the current event
module projection_router
   import projection_router_pkg::*;
#(
   parameter int ADDR_BITS = 6
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [PROJ_BITS-1:0]                 proj_in,
   input  logic                                 proj_valid,
   output logic [PROJ_BITS-1:0]                 proj_out,
   output logic [NUM_REGIONS-1:0]               wr_en_out,
   output logic [NUM_REGIONS*(ADDR_BITS+1)-1:0] wr_addr,
   output logic [2:0]                           bx,
   output logic [NUM_REGIONS-1:0]               overflow,
   output logic [ADDR_BITS+2:0]                 nproj
);

   localparam int NP_W = ADDR_BITS + 3;
   localparam logic [NP_W-1:0] NP_ONE = {{(NP_W-1){1'b0}}, 1'b1};

   state_t                 r_state;
   state_t                 w_stateNext;
   logic [PROJ_BITS-1:0]   r_projOut;
   logic [NUM_REGIONS-1:0] r_wrEn;
   logic [ADDR_BITS:0]     r_wrAddr [NUM_REGIONS];
   logic [2:0]             r_bx;
   logic [NP_W-1:0]        r_nproj;

   logic                   w_active;
   logic [2:0]             w_bxNext;
   logic                   w_page;
   logic [1:0]             w_region;
   logic [NUM_REGIONS-1:0] w_hit;
   logic [NUM_REGIONS-1:0] w_accept;
   logic [NUM_REGIONS-1:0] w_full;
   logic [NUM_REGIONS-1:0] w_overflow;
   logic [ADDR_BITS-1:0]   w_index [NUM_REGIONS];

   // Only reset leaves ROUTE; start from IDLE begins routing.
   always_comb begin
      w_stateNext = r_state;
      if (start) begin
         w_stateNext = ST_ROUTE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // A start in the same cycle as a projection takes effect first, so the
   // projection already belongs to the new event and its page.
   assign w_active = start || (r_state == ST_ROUTE);
   assign w_bxNext = start ? (r_bx + 3'd1) : r_bx;
   assign w_page   = w_bxNext[0];
   assign w_region = proj_in[REGION_MSB:REGION_LSB];

   genvar g;
   generate
      for (g = 0; g < NUM_REGIONS; g++) begin : gRegion
         assign w_hit[g]    = proj_valid && w_active && (w_region == 2'(g));
         assign w_accept[g] = w_hit[g] && (start || !w_full[g]);

         region_counter #(.ADDR_BITS(ADDR_BITS)) uCounter (
            .clk        (clk),
            .reset      (reset),
            .i_clear    (start),
            .i_inc      (w_hit[g]),
            .o_index    (w_index[g]),
            .o_full     (w_full[g]),
            .o_overflow (w_overflow[g])
         );

         // Address holds its last value between writes; only the write pulse qualifies it.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_wrAddr[g] <= '0;
            end else if (w_accept[g]) begin
               r_wrAddr[g] <= {w_page, (start ? {ADDR_BITS{1'b0}} : w_index[g])};
            end
         end

         assign wr_addr[g*(ADDR_BITS+1) +: ADDR_BITS+1] = r_wrAddr[g];
      end
   endgenerate

   // Data path, write pulse, event counter and per-event projection count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_projOut <= '0;
         r_wrEn    <= '0;
         r_bx      <= '0;
         r_nproj   <= '0;
      end else begin
         r_wrEn <= w_accept;
         r_bx   <= w_bxNext;
         if (|w_accept) begin
            r_projOut <= proj_in;
         end
         if (start) begin
            r_nproj <= (|w_accept) ? NP_ONE : '0;
         end else if (|w_accept) begin
            r_nproj <= r_nproj + NP_ONE;
         end
      end
   end

   assign proj_out  = r_projOut;
   assign wr_en_out = r_wrEn;
   assign bx        = r_bx;
   assign overflow  = w_overflow;
   assign nproj     = r_nproj;

endmodule

// File: tb/tb_projection_router.sv
// Directed testbench for projection_router with hand-computed expectations.
module tb_projection_router;

   logic        clk;
   logic        reset;
   logic        start;
   logic [53:0] proj_in;
   logic        proj_valid;
   logic [53:0] proj_out;
   logic [3:0]  wr_en_out;
   logic [27:0] wr_addr;
   logic [2:0]  bx;
   logic [3:0]  overflow;
   logic [8:0]  nproj;

   int checkCount;
   int passCount;

   projection_router #(.ADDR_BITS(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .proj_in    (proj_in),
      .proj_valid (proj_valid),
      .proj_out   (proj_out),
      .wr_en_out  (wr_en_out),
      .wr_addr    (wr_addr),
      .bx         (bx),
      .overflow   (overflow),
      .nproj      (nproj)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Builds a projection whose top two phi bits pick the region
   function automatic logic [53:0] mkProj(input logic [1:0] region, input logic [51:0] body);
      return {region, body};
   endfunction

   function automatic logic [6:0] addrOf(input int r);
      return wr_addr[r*7 +: 7];
   endfunction

   // Drives one cycle of inputs, then samples 1 unit after the rising edge
   task automatic applyStimulus(input logic st, input logic vld, input logic [53:0] p);
      start      = st;
      proj_valid = vld;
      proj_in    = p;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) begin
         passCount++;
      end else begin
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [53:0] p;
      logic [2:0]  expBx;
      checkCount = 0;
      passCount  = 0;
      reset      = 1'b1;
      start      = 1'b0;
      proj_valid = 1'b0;
      proj_in    = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_proj_out", 64'(proj_out), 64'h0);
      checkOutput("rst_wr_en", 64'(wr_en_out), 64'h0);
      checkOutput("rst_wr_addr", 64'(wr_addr), 64'h0);
      checkOutput("rst_bx", 64'(bx), 64'h0);
      checkOutput("rst_overflow", 64'(overflow), 64'h0);
      checkOutput("rst_nproj", 64'(nproj), 64'h0);
      reset = 1'b0;

      // Valid while IDLE is ignored
      applyStimulus(1'b0, 1'b1, mkProj(2'd2, 52'h1));
      checkOutput("idle_wr_en", 64'(wr_en_out), 64'h0);
      checkOutput("idle_nproj", 64'(nproj), 64'h0);
      checkOutput("idle_bx", 64'(bx), 64'h0);

      // First event: bx=1, page 1
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("ev1_bx", 64'(bx), 64'h1);
      checkOutput("ev1_wr_en_quiet", 64'(wr_en_out), 64'h0);

      p = mkProj(2'd2, 52'hA_BCDE_F012_3456);
      applyStimulus(1'b0, 1'b1, p);
      checkOutput("p0_wr_en", 64'(wr_en_out), 64'h4);
      checkOutput("p0_addr_r2", 64'(addrOf(2)), 64'h40);
      checkOutput("p0_proj_out", 64'(proj_out), 64'(p));
      p = mkProj(2'd0, 52'h1_2345_6789_ABCD);
      applyStimulus(1'b0, 1'b1, p);
      checkOutput("p1_wr_en", 64'(wr_en_out), 64'h1);
      checkOutput("p1_addr_r0", 64'(addrOf(0)), 64'h40);
      checkOutput("p1_proj_out", 64'(proj_out), 64'(p));
      applyStimulus(1'b0, 1'b1, mkProj(2'd2, 52'h7));
      checkOutput("p2_wr_en", 64'(wr_en_out), 64'h4);
      checkOutput("p2_addr_r2", 64'(addrOf(2)), 64'h41);
      checkOutput("p2_nproj", 64'(nproj), 64'h3);
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("pulse_deassert", 64'(wr_en_out), 64'h0);

      // Second event (bx=2, page 0): fill region 3 and overflow it
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("ev2_bx", 64'(bx), 64'h2);
      checkOutput("ev2_nproj_clear", 64'(nproj), 64'h0);
      for (int i = 0; i < 65; i++) begin
         applyStimulus(1'b0, 1'b1, mkProj(2'd3, 52'(i)));
         if (i < 64) begin
            checkOutput($sformatf("fill_wr_en_%0d", i), 64'(wr_en_out), 64'h8);
            checkOutput($sformatf("fill_addr_%0d", i), 64'(addrOf(3)), 64'(i));
         end
      end
      checkOutput("drop_wr_en", 64'(wr_en_out), 64'h0);
      checkOutput("drop_overflow", 64'(overflow), 64'h8);
      checkOutput("drop_nproj", 64'(nproj), 64'd64);
      applyStimulus(1'b0, 1'b1, mkProj(2'd1, 52'h55));
      checkOutput("r1_after_ovf_wr_en", 64'(wr_en_out), 64'h2);
      checkOutput("r1_after_ovf_addr", 64'(addrOf(1)), 64'h00);
      checkOutput("r1_after_ovf_overflow", 64'(overflow), 64'h8);
      checkOutput("r1_after_ovf_nproj", 64'(nproj), 64'd65);

      // start together with a projection: bx=3, page 1, slot 0
      p = mkProj(2'd0, 52'hF_0F0F_0F0F_0F0F);
      applyStimulus(1'b1, 1'b1, p);
      checkOutput("sv_bx", 64'(bx), 64'h3);
      checkOutput("sv_wr_en", 64'(wr_en_out), 64'h1);
      checkOutput("sv_addr_r0", 64'(addrOf(0)), 64'h40);
      checkOutput("sv_overflow", 64'(overflow), 64'h0);
      checkOutput("sv_nproj", 64'(nproj), 64'h1);
      checkOutput("sv_proj_out", 64'(proj_out), 64'(p));

      // Eight events, each with a coincident region-1 write: bx wraps, page toggles
      expBx = 3'd3;
      for (int i = 0; i < 8; i++) begin
         expBx = expBx + 3'd1;
         applyStimulus(1'b1, 1'b1, mkProj(2'd1, 52'(i)));
         checkOutput($sformatf("wrap_bx_%0d", i), 64'(bx), 64'(expBx));
         checkOutput($sformatf("wrap_addr_%0d", i), 64'(addrOf(1)), 64'({expBx[0], 6'd0}));
      end

      // Reset in the middle of a burst
      applyStimulus(1'b0, 1'b1, mkProj(2'd2, 52'h10));
      applyStimulus(1'b0, 1'b1, mkProj(2'd2, 52'h11));
      checkOutput("burst_wr_en", 64'(wr_en_out), 64'h4);
      checkOutput("burst_addr_r2", 64'(addrOf(2)), 64'h41);
      reset = 1'b1;
      #1;
      checkOutput("async_proj_out", 64'(proj_out), 64'h0);
      checkOutput("async_wr_en", 64'(wr_en_out), 64'h0);
      checkOutput("async_wr_addr", 64'(wr_addr), 64'h0);
      checkOutput("async_bx", 64'(bx), 64'h0);
      checkOutput("async_nproj", 64'(nproj), 64'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, mkProj(2'd2, 52'h12));
      checkOutput("post_rst_wr_en", 64'(wr_en_out), 64'h0);
      checkOutput("post_rst_nproj", 64'(nproj), 64'h0);
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("post_rst_bx", 64'(bx), 64'h1);
      applyStimulus(1'b0, 1'b1, mkProj(2'd2, 52'h13));
      checkOutput("post_rst_write", 64'(wr_en_out), 64'h4);
      checkOutput("post_rst_addr", 64'(addrOf(2)), 64'h40);
      checkOutput("post_rst_nproj1", 64'(nproj), 64'h1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
